// File: rtl/ppl_pkg.sv
// Shared types and constants for the ray-march ring exit stage: block palette,
// face encoding, exit FSM states and the RGB565 face shader.
package ppl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_DRAIN     = 2'd1,
        ST_WAIT_SWAP = 2'd2
    } state_t;

    localparam logic [1:0] FACE_TOP    = 2'd0;
    localparam logic [1:0] FACE_X      = 2'd1;
    localparam logic [1:0] FACE_Y      = 2'd2;
    localparam logic [1:0] FACE_BOTTOM = 2'd3;

    localparam logic [15:0] PALETTE [16] = '{
        16'h0000, 16'hF800, 16'h07E0, 16'h8410,
        16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
        16'hC618, 16'h4208, 16'hA145, 16'h2589,
        16'h7BEF, 16'hFD20, 16'h39E7, 16'hFFFF
    };

    // Scale each channel by m/8 independently, truncating; no carries cross channels.
    function automatic logic [15:0] shade565(input logic [15:0] c, input logic [1:0] face);
        logic [3:0] m;
        logic [8:0] r;
        logic [9:0] g;
        logic [8:0] b;
        case (face)
            FACE_TOP: m = 4'd8;
            FACE_X:   m = 4'd7;
            FACE_Y:   m = 4'd6;
            default:  m = 4'd4;
        endcase
        r = {4'd0, c[15:11]} * {5'd0, m};
        g = {4'd0, c[10:5]}  * {6'd0, m};
        b = {4'd0, c[4:0]}   * {5'd0, m};
        return {r[7:3], g[8:3], b[7:3]};
    endfunction

endpackage

// File: rtl/ppl_exit_fifo.sv
// Synchronous write FIFO with a registered head entry and an occupancy count.
module pixel_wr_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] head;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop & (cnt != '0);
    assign push_ok = push & ((cnt != (AW+1)'(DEPTH)) | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // Head takes the incoming word when it becomes the oldest entry,
            // otherwise the next stored entry on a pop.
            if (push_ok && ((cnt == '0) || (pop_ok && cnt == (AW+1)'(1))))
                head <= din;
            else if (pop_ok && cnt > (AW+1)'(1))
                head <= mem[rd_ptr + 1'b1];
        end
    end

    assign dout  = head;
    assign count = cnt;

endmodule

// File: rtl/ppl_exit.sv
// Ray-march ring tail: retires finished rays, shades them to RGB565, queues
// framebuffer writes and sequences frame end / swap through scanner_stop.
module ppl_exit
    import ppl_pkg::*;
#(
    parameter int          H_DISP     = 1280,
    parameter int          V_DISP     = 720,
    parameter int          MAX_STEPS  = 20,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] SKY_COLOR  = 16'h867D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_hit,
    input  logic [3:0]  in_block_id,
    input  logic [1:0]  in_face,
    input  logic [4:0]  block_cnt_out,
    input  logic [19:0] pixel_addr_out,
    output logic        next_en,
    output logic        scanner_stop,
    output logic        fb_wr_valid,
    input  logic        fb_wr_ready,
    output logic [19:0] fb_wr_addr,
    output logic [15:0] fb_wr_data,
    output logic        frame_done,
    input  logic        frame_start
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0]  STEP_LAST = 5'(MAX_STEPS - 1);
    localparam logic [19:0] FRAME_PIX = 20'(H_DISP * V_DISP);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_STOP = CW'(FIFO_DEPTH - 2);

    state_t        state;
    state_t        state_nxt;
    logic [19:0]   pix_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [35:0]   head;
    logic [15:0]   colour;
    logic          done;
    logic          full;
    logic          push;
    logic          pop;
    logic          frame_last;

    assign done    = in_hit | (block_cnt_out >= STEP_LAST);
    assign full    = (fifo_cnt == CNT_FULL);
    assign next_en = ~in_valid | (done & ~full);
    assign push    = (state == ST_RUN) & in_valid & done & ~full;

    assign fb_wr_valid = (fifo_cnt != '0);
    assign pop         = fb_wr_valid & fb_wr_ready;
    assign frame_last  = push & (pix_cnt == FRAME_PIX - 20'd1);

    assign colour = in_hit ? shade565(PALETTE[in_block_id], in_face) : SKY_COLOR;

    // Margin of 2 covers rays already past the stop point in the ring.
    assign scanner_stop = (state != ST_RUN) | (fifo_cnt >= CNT_STOP);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:       if (frame_last)   state_nxt = ST_DRAIN;
            ST_DRAIN:     if (!fb_wr_valid) state_nxt = ST_WAIT_SWAP;
            ST_WAIT_SWAP: if (frame_start)  state_nxt = ST_RUN;
            default:                        state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= (state == ST_DRAIN) & ~fb_wr_valid;
            if (frame_last)
                pix_cnt <= '0;
            else if (push)
                pix_cnt <= pix_cnt + 20'd1;
        end
    end

    pixel_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (36)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({pixel_addr_out, colour}),
        .pop   (pop),
        .dout  (head),
        .count (fifo_cnt)
    );

    assign fb_wr_addr = head[35:16];
    assign fb_wr_data = head[15:0];

endmodule

// File: tb/tb_ppl_exit.sv
// Bench for ppl_exit: a full-size instance for colour and backpressure cases and
// a 4x2-frame instance tracked every cycle by a queue-based reference model.
module tb_ppl_exit;

    localparam int FD      = 16;
    localparam int FRAME_B = 8;

    localparam logic [15:0] PAL [16] = '{
        16'h0000, 16'hF800, 16'h07E0, 16'h8410,
        16'h001F, 16'hFFE0, 16'h07FF, 16'hF81F,
        16'hC618, 16'h4208, 16'hA145, 16'h2589,
        16'h7BEF, 16'hFD20, 16'h39E7, 16'hFFFF
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_hit;
    logic [3:0]  in_block_id;
    logic [1:0]  in_face;
    logic [4:0]  block_cnt_out;
    logic [19:0] pixel_addr_out;
    logic        fb_wr_ready, frame_start;

    logic        a_next_en, a_stop, a_vld, a_fdone;
    logic [19:0] a_addr;
    logic [15:0] a_data;
    logic        b_next_en, b_stop, b_vld, b_fdone;
    logic [19:0] b_addr;
    logic [15:0] b_data;

    always #5 clk = ~clk;

    ppl_exit dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_hit(in_hit),
        .in_block_id(in_block_id), .in_face(in_face), .block_cnt_out(block_cnt_out),
        .pixel_addr_out(pixel_addr_out), .next_en(a_next_en), .scanner_stop(a_stop),
        .fb_wr_valid(a_vld), .fb_wr_ready(fb_wr_ready), .fb_wr_addr(a_addr),
        .fb_wr_data(a_data), .frame_done(a_fdone), .frame_start(frame_start)
    );

    ppl_exit #(.H_DISP(4), .V_DISP(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_hit(in_hit),
        .in_block_id(in_block_id), .in_face(in_face), .block_cnt_out(block_cnt_out),
        .pixel_addr_out(pixel_addr_out), .next_en(b_next_en), .scanner_stop(b_stop),
        .fb_wr_valid(b_vld), .fb_wr_ready(fb_wr_ready), .fb_wr_addr(b_addr),
        .fb_wr_data(b_data), .frame_done(b_fdone), .frame_start(frame_start)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] colour_of(input logic hit, input logic [3:0] id,
                                              input logic [1:0] face);
        int r, g, b;
        logic [15:0] c;
        if (!hit) return 16'h867D;
        c = PAL[id];
        r = int'(c[15:11]);
        g = int'(c[10:5]);
        b = int'(c[4:0]);
        case (face)
            2'd1: begin r = r * 7 / 8; g = g * 7 / 8; b = b * 7 / 8; end
            2'd2: begin r = r * 3 / 4; g = g * 3 / 4; b = b * 3 / 4; end
            2'd3: begin r = r / 2;     g = g / 2;     b = b / 2;     end
            default: ;
        endcase
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    function automatic bit ray_done();
        return in_hit || (block_cnt_out >= 5'd19);
    endfunction

    // Reference model for dut_b: 0 = run, 1 = drain, 2 = wait for swap.
    int          m_state = 0;
    int          m_pix   = 0;
    logic [35:0] mq[$];
    logic        m_fd    = 1'b0;
    bit          mon_en  = 1'b0;

    always @(posedge clk) begin
        bit m_push, m_pop, m_empty;
        if (rst) begin
            m_state = 0;
            m_pix   = 0;
            mq.delete();
            m_fd    = 1'b0;
        end else begin
            m_empty = (mq.size() == 0);
            m_pop   = !m_empty && fb_wr_ready;
            m_push  = (m_state == 0) && in_valid && ray_done() && (mq.size() != FD);
            m_fd    = (m_state == 1) && m_empty;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({pixel_addr_out, colour_of(in_hit, in_block_id, in_face)});
            case (m_state)
                0: if (m_push) begin
                       m_pix++;
                       if (m_pix == FRAME_B) begin m_pix = 0; m_state = 1; end
                   end
                1: if (m_empty) m_state = 2;
                2: if (frame_start) m_state = 0;
                default: m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("b_next_en", b_next_en, !in_valid || (ray_done() && mq.size() != FD));
            check("b_scanner_stop", b_stop, (m_state != 0) || (mq.size() >= FD - 2));
            check("b_fb_wr_valid", b_vld, mq.size() != 0);
            if (mq.size() != 0) check("b_fb_head", {b_addr, b_data}, mq[0]);
            check("b_frame_done", b_fdone, m_fd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ray(input logic hit, input logic [3:0] id, input logic [1:0] face,
                       input logic [4:0] cnt, input logic [19:0] addr);
        in_valid = 1'b1; in_hit = hit; in_block_id = id; in_face = face;
        block_cnt_out = cnt; pixel_addr_out = addr;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; frame_start = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [35:0] exp_q[$];
        bit   accepted, push_now;
        int   pulses;
        int   pct;
        in_valid = 0; in_hit = 0; in_block_id = 0; in_face = 0;
        block_cnt_out = 0; pixel_addr_out = 0; fb_wr_ready = 0; frame_start = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_a_valid", a_vld, 0);
        check("rst_a_addr", a_addr, 0);
        check("rst_a_data", a_data, 0);
        check("rst_a_frame_done", a_fdone, 0);
        check("rst_a_stop", a_stop, 0);
        check("rst_a_next_en", a_next_en, 1);
        check("rst_b_valid", b_vld, 0);
        check("rst_b_data", {b_addr, b_data}, 0);
        mon_en = 1'b1;

        // Hit and miss rays on the full-size instance
        fb_wr_ready = 1'b1;
        ray(1, 4'd3, 2'd0, 5'd0, 20'd100);
        #1 check("hit_next_en", a_next_en, 1);
        tick();
        ray(0, 4'd0, 2'd0, 5'd19, 20'd5);
        #1;
        check("hit_valid", a_vld, 1);
        check("hit_addr", a_addr, 20'd100);
        check("hit_data", a_data, PAL[3]);
        check("miss19_next_en", a_next_en, 1);
        tick();
        ray(0, 4'd0, 2'd0, 5'd18, 20'd6);
        #1;
        check("miss_addr", a_addr, 20'd5);
        check("miss_data", a_data, 16'h867D);
        check("miss18_next_en", a_next_en, 0);
        tick();
        in_valid = 1'b0;
        #1 check("miss18_no_push", a_vld, 0);

        // Face shading
        ray(1, 4'd15, 2'd3, 5'd0, 20'd7);
        tick();
        ray(1, 4'd15, 2'd2, 5'd0, 20'd8);
        #1 check("shade_face3", a_data, 16'h7BEF);
        tick();
        ray(1, 4'd15, 2'd1, 5'd0, 20'd9);
        #1 check("shade_face2", a_data, 16'hBDF7);
        tick();
        in_valid = 1'b0;
        #1 check("shade_face1", a_data, colour_of(1'b1, 4'd15, 2'd1));
        tick();

        // Backpressure: fill the FIFO with ready low
        fb_wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ray(1, 4'(i), 2'(i), 5'd0, 20'(200 + i));
            #1 check("bp_stop", a_stop, (i >= 14) ? 1'b1 : 1'b0);
            exp_q.push_back({20'(200 + i), colour_of(1'b1, 4'(i), 2'(i))});
            tick();
        end
        ray(1, 4'd5, 2'd1, 5'd3, 20'd300);
        #1 check("bp_full_next_en", a_next_en, 0);
        tick();
        #1;
        check("bp_full_hold_next_en", a_next_en, 0);
        check("bp_head_hold", {a_addr, a_data}, exp_q[0]);
        fb_wr_ready = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 40 && (exp_q.size() != 0 || !accepted); k++) begin
            push_now = in_valid && (exp_q.size() != FD);
            check("bp_next_en", a_next_en, in_valid ? push_now : 1'b1);
            if (exp_q.size() != 0) check("bp_drain_head", {a_addr, a_data}, exp_q[0]);
            else check("bp_drain_valid", a_vld, 0);
            tick();
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            if (push_now) begin
                exp_q.push_back({20'd300, colour_of(1'b1, 4'd5, 2'd1)});
                in_valid = 1'b0;
                accepted = 1'b1;
            end
        end
        check("bp_17th_retired", {31'd0, accepted, 4'(exp_q.size())}, {31'd0, 1'b1, 4'd0});
        #1 check("bp_empty_after", a_vld, 0);

        // Frame end on the 4x2 instance
        do_reset();
        fb_wr_ready = 1'b1;
        for (int i = 0; i < FRAME_B; i++) begin
            ray(1, 4'(i), 2'd0, 5'd0, 20'(i));
            tick();
        end
        in_valid = 1'b0;
        #1 check("frame_drain_stop", b_stop, 1);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (b_fdone) pulses++;
            tick();
        end
        check("frame_done_pulses", pulses, 1);
        check("frame_wait_stop", b_stop, 1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        #1 check("frame_restart_stop", b_stop, 0);
        for (int i = 0; i < FRAME_B; i++) begin
            ray(0, 4'd0, 2'd0, 5'd19, 20'(50 + i));
            #1 check("frame2_stop_before", b_stop, 0);
            tick();
        end
        in_valid = 1'b0;
        #1 check("frame2_drain_stop", b_stop, 1);

        // Reset in DRAIN with 5 pixels queued
        do_reset();
        fb_wr_ready = 1'b0;
        for (int i = 0; i < FRAME_B; i++) begin
            ray(1, 4'(i + 4), 2'(i), 5'd0, 20'(400 + i));
            tick();
        end
        in_valid = 1'b0;
        fb_wr_ready = 1'b1;
        repeat (3) tick();
        fb_wr_ready = 1'b0;
        #1 check("rstdrain_queued", {b_vld, b_stop}, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstdrain_valid", b_vld, 0);
        check("rstdrain_stop", b_stop, 0);
        for (int k = 0; k < 4; k++) begin
            check("rstdrain_no_frame_done", b_fdone, 0);
            tick();
        end

        // Randomised traffic against the model
        do_reset();
        for (int c = 0; c < 2400; c++) begin
            case ((c / 400) % 4)
                0: pct = 90;
                1: pct = 50;
                2: pct = 15;
                default: pct = 70;
            endcase
            fb_wr_ready   = ($urandom_range(0, 99) < pct);
            frame_start   = (m_state == 2) && ($urandom_range(0, 3) == 0);
            in_valid      = (m_state == 0) && (mq.size() < FD - 2) && ($urandom_range(0, 4) != 0);
            in_hit        = 1'($urandom_range(0, 1));
            in_block_id   = 4'($urandom);
            in_face       = 2'($urandom);
            block_cnt_out = 5'($urandom_range(0, 20));
            pixel_addr_out = 20'($urandom);
            tick();
        end
        in_valid = 1'b0;
        frame_start = 1'b0;
        repeat (4) tick();
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ppl_exit.md
# ppl_exit

Tail stage of the ray-marching ring; the retiring counterpart of the pipeline entry. Each cycle it inspects the ray slot leaving the last march stage and decides one of two things: retire the ray and inject a new one (`next_en`=1), or recirculate it (`next_en`=0). Retired rays are shaded to RGB565 and queued in a small write FIFO toward the framebuffer. The block also counts retired pixels per frame and throttles the scanner through `scanner_stop` for FIFO backpressure and frame-swap sequencing.

## Interface
- `H_DISP`, 1280, pixels per line
- `V_DISP`, 720, lines per frame
- `MAX_STEPS`, 20, block steps before a ray is declared sky
- `FIFO_DEPTH`, 16, pixel write FIFO entries (power of two)
- `SKY_COLOR`, 16'h867D, RGB565 colour for rays that do not hit
- Reset is `rst`, synchronous, active-high; clock is `clk`.

Ports:
- `clk` in 1, clock
- `rst` in 1, synchronous active-high reset
- `in_valid` in 1, tail slot holds a real ray (0 = bubble injected under `scanner_stop`)
- `in_hit` in 1, ray ended inside a solid block
- `in_block_id` in 4, id of the hit block
- `in_face` in 2, hit face: 0 top, 1 x-side, 2 y-side, 3 bottom
- `block_cnt_out` in 5, steps taken so far
- `pixel_addr_out` in 20, destination pixel of the ray
- `next_en` out 1, 1 = retire and inject a fresh ray; 0 = recirculate
- `scanner_stop` out 1, the entry injects a bubble instead of advancing the scanner
- `fb_wr_valid` out 1, a framebuffer write is pending
- `fb_wr_ready` in 1, the framebuffer accepts the write
- `fb_wr_addr` out 20, write address
- `fb_wr_data` out 16, RGB565 pixel
- `frame_done` out 1, one-cycle pulse after the last pixel of a frame is accepted
- `frame_start` in 1, pulse from display/swap logic that releases the next frame

## Operation
- Definitions:
  - `done` = `in_hit` | (`block_cnt_out` >= MAX_STEPS-1)
  - `full` = FIFO count == FIFO_DEPTH
- `next_en` is combinational: `~in_valid | (done & ~full)`.
  - A done ray that meets a full FIFO is recirculated. It is re-evaluated on its next pass, and an identical colour results.
- Push: in RUN, when `in_valid & done & ~full`, push {`pixel_addr_out`, colour} and increment `pix_cnt`.
- Colour:
  - If `in_hit`: `PALETTE[in_block_id]` shaded by face.
    - face 0: unchanged.
    - face 1: each channel × 7/8.
    - face 2: each channel × 3/4.
    - face 3: each channel × 1/2.
    - Channel-wise truncation; no carry between R, G and B.
  - Otherwise `SKY_COLOR`.
- FSM states: RUN, DRAIN, WAIT_SWAP.
  - RUN → DRAIN when a push makes `pix_cnt` == H_DISP*V_DISP. `pix_cnt` clears to 0 on that transition.
  - DRAIN → WAIT_SWAP when the FIFO is empty; `frame_done` pulses on that transition.
  - WAIT_SWAP → RUN on `frame_start`. `frame_start` in any other state is ignored.
- Valid rays arriving in DRAIN or WAIT_SWAP are not pushed and are not counted.
  - The bench checks that none arrive, since the scanner is stopped.
- `scanner_stop` = (state != RUN) | (count >= FIFO_DEPTH-2). The margin of 2 covers rays already in flight past the stop point.
- FIFO: registered head. `fb_wr_valid` = non-empty. Pop on `fb_wr_valid & fb_wr_ready`. `fb_wr_addr`/`fb_wr_data` hold steady while valid and not ready.

## Timing
- Reset values:
  - state RUN, FIFO empty, `pix_cnt` 0.
  - `fb_wr_valid` 0, `fb_wr_addr` 0, `fb_wr_data` 0.
  - `frame_done` 0, `scanner_stop` 0.
  - `next_en` follows its equation (1 while `in_valid`=0).
- Push-to-`fb_wr_valid` latency: 1 cycle when the FIFO is empty.
- Throughput: 1 pixel per cycle with `fb_wr_ready` held high.
- Push and pop in the same cycle:
  - Count is unchanged.
  - Allowed when full only if the pop happens. `full` is evaluated on the pre-pop count, so a push is still refused; the limit is deliberately conservative.
- Reset during any state: queued pixels are discarded, `pix_cnt` clears, and the FSM enters RUN on the next cycle.
- `frame_done` is asserted exactly 1 cycle, registered.
- `pix_cnt` width: 20 bits. Compare against the constant H_DISP*V_DISP (921600).

## Structure
- Package `ppl_pkg`:
  - `PALETTE` (16 × RGB565)
  - face encoding constants
  - FSM state enum
  - `shade565()` function
- One sub-module: `pixel_wr_fifo` (parameterised depth/width, synchronous, count output, registered head).

## Test plan
- Hit ray, block_id 3, face 0, addr 100, `fb_wr_ready`=1 → `next_en`=1 same cycle; next cycle `fb_wr_valid`=1, addr 100, data `PALETTE[3]`.
- Miss ray with `block_cnt_out`=19, addr 5 → data `SKY_COLOR` (16'h867D); `block_cnt_out`=18 with `in_hit`=0 → `next_en`=0, no push.
- Face shading: `PALETTE` entry 16'hFFFF on face 3 → 16'h7BEF; on face 2 → 16'hBDF7.
- Backpressure: `fb_wr_ready`=0, push 14 rays → `scanner_stop` rises at count 14; 2 more fill the FIFO; a 17th done ray gives `next_en`=0 and is not lost; releasing ready then retires it with correct data.
- Frame end: H_DISP=4, V_DISP=2; retire 8 rays → DRAIN, `scanner_stop`=1; after the last pop `frame_done` is a single pulse; `frame_start` → RUN, `scanner_stop`=0, `pix_cnt`=0.
- Reset mid-DRAIN with 5 queued pixels → `fb_wr_valid`=0 next cycle, state RUN, no `frame_done`.
